duty_avg: RTL and testbench
===========================

DUTY_AVG -- requirements
Module: duty_avg

Interface
REQ-001 SHALL have parameter AVG_LOG2, default 3, log2 of the number of periods averaged per result (legal 0..8).
REQ-002 SHALL have port clk  input  1  clock; all logic rising-edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port per_cnt  input  32  period length of last completed period, in clk cycles.
REQ-005 SHALL have port high_cnt  input  32  high time of the same period, in clk cycles.
REQ-006 SHALL have port meas_stb  input  1  single-cycle strobe; per_cnt/high_cnt valid when high.
REQ-007 SHALL have port result_ack  input  1  consumer accepts current result.
REQ-008 SHALL have port result_valid  output  1  result_duty/result_per/result_ovr valid.
REQ-009 SHALL have port result_duty  output  16  averaged duty in 0.1 % units, 0..1000.
REQ-010 SHALL have port result_per  output  32  averaged period, clk cycles.
REQ-011 SHALL have port result_ovr  output  1  one or more strobes dropped during this window's DIVIDE/HOLD.
REQ-012 SHALL have port busy  output  1  high in DIVIDE state.

Function
REQ-013 SHALL implement FSM states ACCUM, DIVIDE, HOLD; ACCUM after reset.
REQ-014 ACCUM: each meas_stb SHALL add per_cnt to 40-bit sum_per, high_cnt to 40-bit sum_high, increment window count.
REQ-015 On the strobe completing 2^AVG_LOG2 samples, SHALL include that sample and enter DIVIDE next cycle.
REQ-016 DIVIDE SHALL run exactly 10 restoring-division iterations, one per cycle, computing floor(sum_high*1000/sum_per), then enter HOLD.
REQ-017 If sum_high >= sum_per and sum_per != 0, result_duty SHALL be 1000 (clamp), divider result discarded.
REQ-018 If sum_per == 0, result_duty SHALL be 0 and result_per 0.
REQ-019 result_per SHALL be sum_per >> AVG_LOG2, truncated, lower 32 bits.
REQ-020 Latency: final strobe sampled at edge k SHALL give result_valid high after edge k+11, fixed for all data, clamp and zero cases.
REQ-021 HOLD: result_valid and all result outputs SHALL stay stable until result_ack is sampled high.
REQ-022 Accepted ack SHALL drop result_valid next cycle, clear sums/window count, return to ACCUM.
REQ-023 result_ack while result_valid low SHALL be ignored.
REQ-024 meas_stb in DIVIDE or HOLD SHALL be dropped and set an internal overrun flag, copied to result_ovr when the next result is presented, then cleared.
REQ-025 meas_stb coincident with an accepted ack SHALL become sample 1 of the new window, not an overrun.
REQ-026 result outputs SHALL keep last values after ack until the next result overwrites them.

Reset
REQ-027 reset low SHALL asynchronously force state ACCUM, sums, window count, overrun flag, divider registers and all outputs to 0.
REQ-028 reset asserted mid-DIVIDE or mid-HOLD SHALL abandon the window; first strobe after release is sample 1.

Structure
REQ-029 Shared package SHALL hold state encoding, DUTY_FULL_SCALE = 1000, DIV_ITER = 10, SUM_W = 40.
REQ-030 Division SHALL be a sub-module duty_div (start/done, 50-bit numerator, 40-bit divisor, 10-bit quotient, fixed 10 cycles).

Verification (AVG_LOG2 = 3)
REQ-031 8 strobes per=1000, high=250 -> result_duty 250, result_per 1000, result_ovr 0, valid 11 cycles after last strobe.
REQ-032 8 strobes per=3, high=1 -> result_duty 333 (truncated); per=1000, high=1200 -> result_duty 1000.
REQ-033 8 strobes per=0, high=0 -> result_duty 0, result_per 0, same latency.
REQ-034 Result held unacked, 3 extra strobes -> outputs unchanged; after ack and next full window, result_ovr 1.
REQ-035 Ack and strobe (per=500, high=100) same cycle, then 7 more identical -> next result_duty 200, result_ovr 0.
REQ-036 reset pulsed during DIVIDE -> all outputs 0 immediately, no result; fresh window of 8 completes normally.

Source files
------------

// File: rtl/duty_avg_pkg.sv
// Shared constants, state encoding and scaling helper for the duty-cycle averager.
package duty_avg_pkg;

  localparam int unsigned SUM_W    = 40;
  localparam int unsigned NUM_W    = 50;
  localparam int unsigned Q_W      = 10;
  localparam int unsigned DIV_ITER = 10;

  localparam logic [9:0] DUTY_FULL_SCALE = 10'd1000;

  typedef logic [1:0] state_t;

  localparam state_t ST_ACCUM  = 2'd0;
  localparam state_t ST_DIVIDE = 2'd1;
  localparam state_t ST_HOLD   = 2'd2;

  function automatic logic [NUM_W-1:0] scale_duty(input logic [SUM_W-1:0] s);
    return {{(NUM_W-SUM_W){1'b0}}, s} * {{(NUM_W-10){1'b0}}, DUTY_FULL_SCALE};
  endfunction

endpackage

// File: rtl/duty_div.sv
// Fixed-latency restoring divider: loads on start, produces a 10-bit quotient
// after DIV_ITER cycles; the caller guarantees num < den * 2^Q_W.
module duty_div
  import duty_avg_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [SUM_W-1:0] den,
  output logic             done,
  output logic [Q_W-1:0]   quot
);

  logic [NUM_W-1:0] rem;
  logic [NUM_W-1:0] dsh;
  logic [3:0]       iter;
  logic             run;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem  <= '0;
      dsh  <= '0;
      iter <= '0;
      run  <= 1'b0;
      done <= 1'b0;
      quot <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem  <= num;
        // Divisor pre-shifted to the weight of the quotient MSB.
        dsh  <= {{(NUM_W-SUM_W-Q_W+1){1'b0}}, den, {(Q_W-1){1'b0}}};
        quot <= '0;
        iter <= 4'(DIV_ITER);
        run  <= 1'b1;
      end else if (run) begin
        if (rem >= dsh) begin
          rem  <= rem - dsh;
          quot <= {quot[Q_W-2:0], 1'b1};
        end else begin
          quot <= {quot[Q_W-2:0], 1'b0};
        end
        dsh  <= dsh >> 1;
        iter <= iter - 4'd1;
        if (iter == 4'd1) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/duty_avg.sv
// Averages 2^AVG_LOG2 period/high-time measurements into a duty cycle (0.1 %
// units) and mean period, presented with a valid/ack handshake.
module duty_avg
  import duty_avg_pkg::*;
#(
  parameter int unsigned AVG_LOG2 = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] per_cnt,
  input  logic [31:0] high_cnt,
  input  logic        meas_stb,
  input  logic        result_ack,
  output logic        result_valid,
  output logic [15:0] result_duty,
  output logic [31:0] result_per,
  output logic        result_ovr,
  output logic        busy
);

  localparam logic [8:0] WIN = 9'(1 << AVG_LOG2);

  state_t           state;
  logic [SUM_W-1:0] sum_per;
  logic [SUM_W-1:0] sum_high;
  logic [8:0]       win_cnt;
  logic             ovr_flag;

  logic             hold_ack;
  logic             take;
  logic             last;
  logic [SUM_W-1:0] per_nxt;
  logic [SUM_W-1:0] high_nxt;
  logic [8:0]       cnt_nxt;
  logic [15:0]      duty_sel;
  logic             div_done;
  logic [Q_W-1:0]   div_quot;

  // An accepted ack restarts the window, so a coincident strobe accumulates from zero.
  always_comb begin
    hold_ack = (state == ST_HOLD) && result_ack;
    take     = meas_stb && ((state == ST_ACCUM) || hold_ack);
    per_nxt  = (hold_ack ? '0 : sum_per)  + {{(SUM_W-32){1'b0}}, per_cnt};
    high_nxt = (hold_ack ? '0 : sum_high) + {{(SUM_W-32){1'b0}}, high_cnt};
    cnt_nxt  = (hold_ack ? '0 : win_cnt) + 9'd1;
    last     = take && (cnt_nxt == WIN);
  end

  always_comb begin
    duty_sel = {{(16-Q_W){1'b0}}, div_quot};
    if (sum_per == '0)
      duty_sel = '0;
    else if (sum_high >= sum_per)
      duty_sel = 16'(DUTY_FULL_SCALE);
  end

  duty_div u_div (
    .clk   (clk),
    .reset (reset),
    .start (last),
    .num   (scale_duty(high_nxt)),
    .den   (per_nxt),
    .done  (div_done),
    .quot  (div_quot)
  );

  assign busy = (state == ST_DIVIDE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_ACCUM;
      sum_per      <= '0;
      sum_high     <= '0;
      win_cnt      <= '0;
      ovr_flag     <= 1'b0;
      result_valid <= 1'b0;
      result_duty  <= '0;
      result_per   <= '0;
      result_ovr   <= 1'b0;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (take) begin
            sum_per  <= per_nxt;
            sum_high <= high_nxt;
            win_cnt  <= last ? '0 : cnt_nxt;
            if (last) state <= ST_DIVIDE;
          end
        end
        ST_DIVIDE: begin
          if (meas_stb) ovr_flag <= 1'b1;
          if (div_done) begin
            state        <= ST_HOLD;
            result_valid <= 1'b1;
            result_duty  <= duty_sel;
            result_per   <= 32'(sum_per >> AVG_LOG2);
            result_ovr   <= ovr_flag | meas_stb;
            ovr_flag     <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (result_ack) begin
            result_valid <= 1'b0;
            sum_per      <= take ? per_nxt  : '0;
            sum_high     <= take ? high_nxt : '0;
            win_cnt      <= (take && !last) ? cnt_nxt : '0;
            state        <= last ? ST_DIVIDE : ST_ACCUM;
          end else if (meas_stb) begin
            ovr_flag <= 1'b1;
          end
        end
        default: state <= ST_ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_duty_avg.sv
// Scoreboard bench for duty_avg with AVG_LOG2 = 3.
module tb_duty_avg;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] per_cnt;
  logic [31:0] high_cnt;
  logic        meas_stb;
  logic        result_ack;
  logic        result_valid;
  logic [15:0] result_duty;
  logic [31:0] result_per;
  logic        result_ovr;
  logic        busy;

  duty_avg #(.AVG_LOG2(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .per_cnt      (per_cnt),
    .high_cnt     (high_cnt),
    .meas_stb     (meas_stb),
    .result_ack   (result_ack),
    .result_valid (result_valid),
    .result_duty  (result_duty),
    .result_per   (result_per),
    .result_ovr   (result_ovr),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint unsigned duty;
    longint unsigned per;
    bit              ovr;
    int              cyc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  bit   have_cur   = 1'b0;
  bit   prev_valid = 1'b0;

  longint unsigned m_sp, m_sh;
  int              m_cnt      = 0;
  bit              m_busy     = 1'b0;
  int              m_pres     = 0;
  bit              m_ovr_next = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock of stimulus; e is the rising edge that samples these inputs.
  task automatic step(input bit stb, input int unsigned per, input int unsigned high, input bit ack);
    int   e;
    exp_t x;
    @(negedge clk);
    meas_stb   = stb;
    per_cnt    = per;
    high_cnt   = high;
    result_ack = ack;
    e = cyc + 1;
    if (ack && m_busy && (e >= m_pres + 1)) begin
      m_busy = 1'b0;
      m_sp   = 0;
      m_sh   = 0;
      m_cnt  = 0;
    end
    if (stb) begin
      if (!m_busy) begin
        m_sp += per;
        m_sh += high;
        m_cnt++;
        if (m_cnt == 8) begin
          x.per  = (m_sp >> 3) & 64'hFFFF_FFFF;
          if (m_sp == 0)        x.duty = 0;
          else if (m_sh >= m_sp) x.duty = 1000;
          else                  x.duty = (m_sh * 1000) / m_sp;
          x.ovr  = m_ovr_next;
          x.cyc  = e + 11;
          m_ovr_next = 1'b0;
          sb.push_back(x);
          m_busy = 1'b1;
          m_pres = e + 11;
          m_cnt  = 0;
        end
      end else if (e <= m_pres && sb.size() > 0) begin
        x = sb.pop_back();
        x.ovr = 1'b1;
        sb.push_back(x);
      end else begin
        m_ovr_next = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 40 && !result_valid; i++) step(1'b0, 0, 0, 1'b0);
    check("wait_valid", result_valid, 1);
  endtask

  task automatic ack_it();
    step(1'b0, 0, 0, 1'b1);
    step(1'b0, 0, 0, 1'b0);
    check("ack_drop", result_valid, 0);
  endtask

  task automatic window(input int n, input int unsigned per, input int unsigned high);
    for (int i = 0; i < n; i++) step(1'b1, per, high, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    sb.delete();
    m_sp = 0; m_sh = 0; m_cnt = 0; m_busy = 1'b0; m_ovr_next = 1'b0;
    have_cur   = 1'b0;
    prev_valid = 1'b0;
    #1;
    check("rst_valid", result_valid, 0);
    check("rst_duty", result_duty, 0);
    check("rst_per", result_per, 0);
    check("rst_ovr", result_ovr, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    #2 reset = 1'b1;
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (result_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          check("spurious_valid", result_valid, 0);
        end else begin
          cur = sb.pop_front();
          have_cur = 1'b1;
          check("latency", cyc, cur.cyc);
          check("duty", result_duty, cur.duty);
          check("per", result_per, cur.per);
          check("ovr", result_ovr, cur.ovr);
        end
      end else if (have_cur) begin
        check("stable_duty", result_duty, cur.duty);
        check("stable_per", result_per, cur.per);
        check("stable_ovr", result_ovr, cur.ovr);
      end
      prev_valid = result_valid;
    end
  end

  initial begin
    reset      = 1'b0;
    meas_stb   = 1'b0;
    result_ack = 1'b0;
    per_cnt    = '0;
    high_cnt   = '0;
    m_sp = 0;
    m_sh = 0;
    do_reset();

    window(8, 1000, 250);
    step(1'b0, 0, 0, 1'b0);
    check("busy", busy, 1);
    wait_valid();
    ack_it();

    window(8, 3, 1);
    idle(1);
    step(1'b1, 7, 7, 1'b0);
    wait_valid();
    ack_it();

    window(8, 1000, 1200);
    wait_valid();
    ack_it();

    window(8, 0, 0);
    wait_valid();
    ack_it();

    window(4, 1000, 500);
    step(1'b0, 0, 0, 1'b1);
    window(4, 1000, 500);
    wait_valid();
    window(3, 9, 9);
    idle(2);
    ack_it();
    window(8, 2000, 500);
    wait_valid();

    step(1'b1, 500, 100, 1'b1);
    step(1'b1, 500, 100, 1'b0);
    check("ack_strobe_drop", result_valid, 0);
    window(6, 500, 100);
    wait_valid();
    ack_it();

    window(8, 800, 200);
    idle(3);
    do_reset();
    idle(2);
    window(8, 800, 200);
    wait_valid();
    ack_it();

    idle(3);
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
